// File: rtl/sounder_seq.sv
// Chip/sweep sequencer for a PN channel sounder: paces the transmitter, the
// correlator accumulate strobes and the per-bin readout of the receive buffer.
//
//   state | meaning
//   IDLE  | stopped; counters held at zero
//   RUN   | transmitting and (if rx_en) accumulating sweeps
//   DUMP  | one sweep of buffer readout; transmitter keeps running
module sounder_seq #(
    parameter logic [6:0] ADDR_MODE = 7'd32,
    parameter logic [6:0] ADDR_CFG  = 7'd33
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  saddr_i,
    input  logic [31:0] sdata_i,
    input  logic        s_strobe_i,
    output logic        tx_strobe_o,
    output logic        rx_strobe_o,
    output logic        dump_strobe_o,
    output logic [15:0] phase_o,
    output logic        first_sweep_o,
    output logic        loopback_o,
    output logic        busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DUMP = 2'd2;

    logic [2:0]  mode_q, mode_d;
    logic [3:0]  deg_q, deg_d;
    logic [3:0]  avg_q, avg_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] sweep_q, sweep_d;
    logic [15:0] div_cnt_q, div_cnt_d;

    logic        tx_q, tx_d, rx_q, rx_d, dump_q, dump_d;
    logic        first_q, first_d, busy_q, busy_d;
    logic [15:0] phase_out_q, phase_out_d;

    logic        wr_mode, wr_cfg, wr_any;
    logic        tx_en, rx_en, active, tick, sweep_end;
    logic [3:0]  deg_eff;
    logic [16:0] deg_pow, avg_pow;
    logic [15:0] last_phase, last_sweep;
    logic        unused_sdata;

    assign unused_sdata = ^sdata_i[31:24];

    assign wr_mode = s_strobe_i && (saddr_i == ADDR_MODE);
    assign wr_cfg  = s_strobe_i && (saddr_i == ADDR_CFG);
    assign wr_any  = wr_mode || wr_cfg;

    assign tx_en = mode_q[0];
    assign rx_en = mode_q[1];

    // Degrees below 2 would give a zero- or one-chip sequence, so clamp to 2.
    assign deg_eff    = (deg_q < 4'd2) ? 4'd2 : deg_q;
    assign deg_pow    = 17'd1 << deg_eff;
    assign last_phase = 16'(deg_pow - 17'd2);
    assign avg_pow    = 17'd1 << avg_q;
    assign last_sweep = 16'(avg_pow - 17'd1);

    assign active    = (state_q == S_RUN) || (state_q == S_DUMP);
    assign tick      = active && (div_cnt_q == 16'd0) && !wr_any;
    assign sweep_end = tick && (phase_q == last_phase);

    always_comb begin
        mode_d    = wr_mode ? sdata_i[2:0] : mode_q;
        deg_d     = wr_cfg ? sdata_i[3:0] : deg_q;
        avg_d     = wr_cfg ? sdata_i[7:4] : avg_q;
        div_d     = wr_cfg ? sdata_i[23:8] : div_q;
        state_d   = state_q;
        phase_d   = phase_q;
        sweep_d   = sweep_q;
        div_cnt_d = div_cnt_q;

        if (wr_any) begin
            state_d   = S_IDLE;
            phase_d   = 16'd0;
            sweep_d   = 16'd0;
            div_cnt_d = 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    phase_d   = 16'd0;
                    sweep_d   = 16'd0;
                    div_cnt_d = 16'd0;
                    if (tx_en || rx_en) state_d = S_RUN;
                end
                S_RUN, S_DUMP: begin
                    div_cnt_d = (div_cnt_q == div_q) ? 16'd0 : div_cnt_q + 16'd1;
                    if (tick) phase_d = sweep_end ? 16'd0 : phase_q + 16'd1;
                    if (sweep_end) begin
                        if (state_q == S_DUMP) begin
                            state_d   = S_RUN;
                            sweep_d   = 16'd0;
                            div_cnt_d = 16'd0;
                        end else if (rx_en && (sweep_q == last_sweep)) begin
                            state_d   = S_DUMP;
                            sweep_d   = 16'd0;
                            div_cnt_d = 16'd0;
                        end else begin
                            sweep_d = sweep_q + 16'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the pre-edge counters so each strobe lines
    // up with the phase value it refers to.
    always_comb begin
        tx_d        = tick && tx_en;
        rx_d        = tick && rx_en && (state_q == S_RUN);
        dump_d      = tick && (state_q == S_DUMP);
        first_d     = !wr_any && (state_q == S_RUN) && (sweep_q == 16'd0);
        busy_d      = (state_d != S_IDLE);
        phase_out_d = wr_any ? 16'd0 : phase_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q      <= 3'd0;
            deg_q       <= 4'd0;
            avg_q       <= 4'd0;
            div_q       <= 16'd0;
            state_q     <= S_IDLE;
            phase_q     <= 16'd0;
            sweep_q     <= 16'd0;
            div_cnt_q   <= 16'd0;
            tx_q        <= 1'b0;
            rx_q        <= 1'b0;
            dump_q      <= 1'b0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            phase_out_q <= 16'd0;
        end else begin
            mode_q      <= mode_d;
            deg_q       <= deg_d;
            avg_q       <= avg_d;
            div_q       <= div_d;
            state_q     <= state_d;
            phase_q     <= phase_d;
            sweep_q     <= sweep_d;
            div_cnt_q   <= div_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            dump_q      <= dump_d;
            first_q     <= first_d;
            busy_q      <= busy_d;
            phase_out_q <= phase_out_d;
        end
    end

    assign tx_strobe_o   = tx_q;
    assign rx_strobe_o   = rx_q;
    assign dump_strobe_o = dump_q;
    assign first_sweep_o = first_q;
    assign busy_o        = busy_q;
    assign phase_o       = phase_out_q;
    assign loopback_o    = mode_q[2];

endmodule
